cpu_sm_bus_arbiter: RTL and testbench

- 68030 bus-mastership arbiter feeding the CPU state machine: requests the bus for DMA, completes the BR_/BG_/BGACK_ handshake and grants tenure (OWN) to the CPU state machine.
- Produces the CYCLEDONE qualifier consumed by the CPU state machine output decode.
- Sits between the DMA channel request logic and the CPU state machine; drives the BR_ and BGACK_ pins through pad registers.

---
 rtl/cpu_sm_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cpu_sm_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sm_bus_arbiter.sv
// 68030 bus-mastership arbiter for the CPU state machine.
// Requests the bus on behalf of the DMA channel and runs the BR_/BG_/BGACK_
// handshake. It gives the CPU state machine a tenure window (OWN) and marks
// the end of each tenure with a one-cycle CYCLEDONE pulse.
//
// Each pin output (BR_, BGACK_, OWN, CYCLEDONE) comes from a flop. Every flop
// is loaded from the *next* state, so the pins line up with ARB_STATE in
// every cycle and no input has a combinational path to a pin.
//
// Handshake semantics: DMA_REQ is a level that stays high until the request
// is served or withdrawn. DMA_DONE is a single-cycle pulse. BG_ is sampled
// only after the two-flop synchroniser. The bus counts as free only when
// AS_IN_, both DSACK_ bits, STERM_ and BGACK_IN_ are all negated.
module cpu_sm_bus_arbiter #(
  parameter int HOLD_MAX    = 64,
  parameter int RELEASE_GAP = 4
) (
  input  logic       CLK45,
  input  logic       RESET,
  input  logic       DMA_REQ,
  input  logic       DMA_DONE,
  input  logic       CPU_IDLE,
  input  logic       BG_,
  input  logic       AS_IN_,
  input  logic [1:0] DSACK_,
  input  logic       STERM_,
  input  logic       BGACK_IN_,
  output logic       BR_,
  output logic       BGACK_,
  output logic       OWN,
  output logic       CYCLEDONE,
  output logic [2:0] ARB_STATE
);

  localparam int MAX_COUNT = (HOLD_MAX > RELEASE_GAP) ? HOLD_MAX : RELEASE_GAP;
  localparam int CW        = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(HOLD_MAX);
  localparam logic [CW-1:0] GAP_LAST   = CW'((RELEASE_GAP > 0) ? RELEASE_GAP - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_FREE = 3'd2,
    ST_OWNED     = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_GAP       = 3'd5
  } arb_state_e;

  arb_state_e    state_q, state_d;
  logic          bg_meta_q, bg_s_q;
  logic [CW-1:0] tenure_cnt_q, tenure_cnt_d;
  logic [CW-1:0] gap_cnt_q, gap_cnt_d;
  logic          br_n_q, br_n_d;
  logic          bgack_n_q, bgack_n_d;
  logic          own_q, own_d;
  logic          cycledone_q, cycledone_d;

  logic bus_free;
  logic timeout;
  logic gap_done;

  assign bus_free = AS_IN_ & DSACK_[1] & DSACK_[0] & STERM_ & BGACK_IN_;
  // A timeout waits for CPU_IDLE, so it never cuts off a bus cycle in progress.
  assign timeout  = (HOLD_MAX != 0) && (tenure_cnt_q == HOLD_LIMIT) && CPU_IDLE;
  // With RELEASE_GAP of 0 or 1, GAP still lasts one cycle.
  assign gap_done = (RELEASE_GAP <= 1) || (gap_cnt_q >= GAP_LAST);

  // Two-flop synchroniser for the asynchronous BG_ pin.
  always_ff @(posedge CLK45 or posedge RESET) begin
    if (RESET) begin
      bg_meta_q <= 1'b1;
      bg_s_q    <= 1'b1;
    end else begin
      bg_meta_q <= BG_;
      bg_s_q    <= bg_meta_q;
    end
  end

  // State, counter and pin registers; reset drops BGACK_ without waiting for a clock.
  always_ff @(posedge CLK45 or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      tenure_cnt_q <= '0;
      gap_cnt_q    <= '0;
      br_n_q       <= 1'b1;
      bgack_n_q    <= 1'b1;
      own_q        <= 1'b0;
      cycledone_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tenure_cnt_q <= tenure_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      br_n_q       <= br_n_d;
      bgack_n_q    <= bgack_n_d;
      own_q        <= own_d;
      cycledone_q  <= cycledone_d;
    end
  end

  // Next-state and counter logic, then pin values decoded from the next state.
  always_comb begin
    state_d      = state_q;
    tenure_cnt_d = tenure_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    br_n_d       = 1'b1;
    bgack_n_d    = 1'b1;
    own_d        = 1'b0;
    cycledone_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (DMA_REQ) state_d = ST_REQ;
      end
      ST_REQ: begin
        // Withdrawal wins over a grant that arrives in the same cycle.
        if (!DMA_REQ)     state_d = ST_IDLE;
        else if (!bg_s_q) state_d = ST_WAIT_FREE;
      end
      ST_WAIT_FREE: begin
        if (bus_free) begin
          state_d      = ST_OWNED;
          tenure_cnt_d = '0;
        end
      end
      ST_OWNED: begin
        if (tenure_cnt_q != HOLD_LIMIT) tenure_cnt_d = tenure_cnt_q + CW'(1);
        // DMA_DONE and a timeout in the same cycle merge into a single exit.
        if (DMA_DONE || timeout) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
      ST_GAP: begin
        if (gap_done) state_d = ST_IDLE;
        else          gap_cnt_d = gap_cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_REQ, ST_WAIT_FREE: br_n_d = 1'b0;
      ST_OWNED: begin
        bgack_n_d = 1'b0;
        own_d     = 1'b1;
      end
      ST_RELEASE: begin
        bgack_n_d   = 1'b0;
        cycledone_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign BR_       = br_n_q;
  assign BGACK_    = bgack_n_q;
  assign OWN       = own_q;
  assign CYCLEDONE = cycledone_q;
  assign ARB_STATE = state_q;

endmodule

// File: tb/tb_cpu_sm_bus_arbiter.sv
// Directed bench for cpu_sm_bus_arbiter.
// dut_a uses the default parameters (HOLD_MAX=64, RELEASE_GAP=4).
// dut_b uses HOLD_MAX=8, RELEASE_GAP=0 and covers the timeout and zero-gap boundaries.
// Both instances share every input.
// Cycle c is the interval that starts 1 time unit after rising edge c. The
// bench samples outputs and drives inputs at that point. Cycle 0 is the first
// cycle after reset is released.
module tb_cpu_sm_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       dma_req, dma_done, cpu_idle, bg_n, as_n, sterm_n, bgack_in_n;
  logic [1:0] dsack_n;

  logic       a_br_n, a_bgack_n, a_own, a_cd;
  logic [2:0] a_state;
  logic       b_br_n, b_bgack_n, b_own, b_cd;
  logic [2:0] b_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_sm_bus_arbiter #(.HOLD_MAX(64), .RELEASE_GAP(4)) dut_a (
    .CLK45(clk), .RESET(rst), .DMA_REQ(dma_req), .DMA_DONE(dma_done),
    .CPU_IDLE(cpu_idle), .BG_(bg_n), .AS_IN_(as_n), .DSACK_(dsack_n),
    .STERM_(sterm_n), .BGACK_IN_(bgack_in_n), .BR_(a_br_n), .BGACK_(a_bgack_n),
    .OWN(a_own), .CYCLEDONE(a_cd), .ARB_STATE(a_state)
  );

  cpu_sm_bus_arbiter #(.HOLD_MAX(8), .RELEASE_GAP(0)) dut_b (
    .CLK45(clk), .RESET(rst), .DMA_REQ(dma_req), .DMA_DONE(dma_done),
    .CPU_IDLE(cpu_idle), .BG_(bg_n), .AS_IN_(as_n), .DSACK_(dsack_n),
    .STERM_(sterm_n), .BGACK_IN_(bgack_in_n), .BR_(b_br_n), .BGACK_(b_bgack_n),
    .OWN(b_own), .CYCLEDONE(b_cd), .ARB_STATE(b_state)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive idle inputs and hold reset for a few edges, then release it at the start of cycle 0.
  task automatic test_reset();
    logic [6:0] exp_v;
    rst = 1'b1; dma_req = 1'b0; dma_done = 1'b0; cpu_idle = 1'b1; bg_n = 1'b1;
    as_n = 1'b1; dsack_n = 2'b11; sterm_n = 1'b1; bgack_in_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_v = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    total++;
    if ({a_state, a_br_n, a_bgack_n, a_own, a_cd} !== exp_v) begin
      bad++;
      $display("FAIL reset_a got=%b exp=%b", {a_state, a_br_n, a_bgack_n, a_own, a_cd}, exp_v);
    end
    total++;
    if ({b_state, b_br_n, b_bgack_n, b_own, b_cd} !== exp_v) begin
      bad++;
      $display("FAIL reset_b got=%b exp=%b", {b_state, b_br_n, b_bgack_n, b_own, b_cd}, exp_v);
    end
    rst = 1'b0;
  endtask

  // DMA_REQ at c0, BG_ low at c2, DMA_DONE at c20; checks dut_a every cycle.
  task automatic test_normal_tenure();
    logic [2:0] es;
    logic [6:0] exp_v;
    test_reset();
    for (int c = 0; c <= 28; c++) begin
      dma_req  = (c < 20);
      bg_n     = !(c >= 2 && c < 8);
      dma_done = (c == 20);
      if (c == 0)       es = 3'd0;
      else if (c <= 4)  es = 3'd1;
      else if (c == 5)  es = 3'd2;
      else if (c <= 20) es = 3'd3;
      else if (c == 21) es = 3'd4;
      else if (c <= 25) es = 3'd5;
      else              es = 3'd0;
      exp_v = {es, !(c >= 1 && c <= 5), !(c >= 6 && c <= 21), (c >= 6 && c <= 20), (c == 21)};
      total++;
      if ({a_state, a_br_n, a_bgack_n, a_own, a_cd} !== exp_v) begin
        bad++;
        $display("FAIL normal c=%0d got=%b exp=%b", c, {a_state, a_br_n, a_bgack_n, a_own, a_cd}, exp_v);
      end
      next_cycle();
    end
    dma_done = 1'b0;
  endtask

  // AS_IN_ held low through c14: both DUTs wait in WAIT_FREE until c16.
  task automatic test_bus_busy();
    logic [4:0] exp_v;
    test_reset();
    for (int c = 0; c <= 16; c++) begin
      dma_req = 1'b1;
      bg_n    = !(c >= 2 && c < 8);
      as_n    = (c >= 15);
      if (c >= 5) begin
        exp_v = (c <= 15) ? {3'd2, 1'b0, 1'b1} : {3'd3, 1'b1, 1'b0};
        total++;
        if ({a_state, a_br_n, a_bgack_n} !== exp_v) begin
          bad++;
          $display("FAIL busy_a c=%0d got=%b exp=%b", c, {a_state, a_br_n, a_bgack_n}, exp_v);
        end
        total++;
        if ({b_state, b_br_n, b_bgack_n} !== exp_v) begin
          bad++;
          $display("FAIL busy_b c=%0d got=%b exp=%b", c, {b_state, b_br_n, b_bgack_n}, exp_v);
        end
      end
      next_cycle();
    end
    as_n = 1'b1;
  endtask

  // dut_b: count reaches 8 at c14, CPU busy c14..c16, release at c18, zero-gap IDLE at c20.
  task automatic test_timeout();
    logic [2:0] es;
    int pulses;
    test_reset();
    pulses = 0;
    for (int c = 0; c <= 26; c++) begin
      dma_req  = (c < 18);
      bg_n     = !(c >= 2 && c < 8);
      cpu_idle = !(c >= 14 && c <= 16);
      if (c == 0)       es = 3'd0;
      else if (c <= 4)  es = 3'd1;
      else if (c == 5)  es = 3'd2;
      else if (c <= 17) es = 3'd3;
      else if (c == 18) es = 3'd4;
      else if (c == 19) es = 3'd5;
      else              es = 3'd0;
      total++;
      if ({b_state, b_cd} !== {es, (c == 18)}) begin
        bad++;
        $display("FAIL timeout c=%0d got=%b exp=%b", c, {b_state, b_cd}, {es, (c == 18)});
      end
      if (b_cd === 1'b1) pulses++;
      next_cycle();
    end
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL timeout_pulses got=%0d exp=1", pulses);
    end
    cpu_idle = 1'b1;
  endtask

  // DMA_DONE lands in the same cycle as the dut_b timeout (c14): one exit, one pulse.
  task automatic test_done_with_timeout();
    int pulses_b;
    int pulses_a;
    test_reset();
    pulses_b = 0;
    pulses_a = 0;
    for (int c = 0; c <= 24; c++) begin
      dma_req  = (c < 14);
      bg_n     = !(c >= 2 && c < 8);
      dma_done = (c == 14);
      if (c == 14 || c == 15) begin
        total++;
        if ({b_state, b_cd} !== ((c == 14) ? 4'b0110 : 4'b1001)) begin
          bad++;
          $display("FAIL done_timeout c=%0d got=%b", c, {b_state, b_cd});
        end
      end
      if (b_cd === 1'b1) pulses_b++;
      if (a_cd === 1'b1) pulses_a++;
      next_cycle();
    end
    dma_done = 1'b0;
    total++;
    if (pulses_b !== 1) begin
      bad++;
      $display("FAIL done_timeout_pulses_b got=%0d exp=1", pulses_b);
    end
    total++;
    if (pulses_a !== 1) begin
      bad++;
      $display("FAIL done_pulses_a got=%0d exp=1", pulses_a);
    end
  endtask

  // DMA_REQ drops at c4, when bg_s first goes low: back to IDLE with no grant.
  task automatic test_withdrawal();
    logic [5:0] exp_v;
    test_reset();
    for (int c = 0; c <= 12; c++) begin
      dma_req = (c < 4);
      bg_n    = !(c >= 2 && c < 7);
      exp_v = {((c >= 1 && c <= 4) ? 3'd1 : 3'd0), !(c >= 1 && c <= 4), 1'b1, 1'b0};
      total++;
      if ({a_state, a_br_n, a_bgack_n, a_own} !== exp_v) begin
        bad++;
        $display("FAIL withdraw c=%0d got=%b exp=%b", c, {a_state, a_br_n, a_bgack_n, a_own}, exp_v);
      end
      next_cycle();
    end
  endtask

  // Reset raised mid-cycle while dut_a is OWNED; pins must drop before the next edge.
  task automatic test_async_reset();
    test_reset();
    for (int c = 0; c <= 8; c++) begin
      dma_req = 1'b1;
      bg_n    = !(c >= 2 && c < 8);
      next_cycle();
    end
    total++;
    if ({a_state, a_bgack_n, a_own} !== {3'd3, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL async_pre got=%b exp=%b", {a_state, a_bgack_n, a_own}, {3'd3, 1'b0, 1'b1});
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({a_state, a_br_n, a_bgack_n, a_own, a_cd} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got=%b exp=%b", {a_state, a_br_n, a_bgack_n, a_own, a_cd},
               {3'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    end
    dma_req = 1'b0;
    bg_n    = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal_tenure();
    test_bus_busy();
    test_timeout();
    test_done_with_timeout();
    test_withdrawal();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
